// File: rtl/bubbledrive8_pkg.sv
// Shared types and constants for the BubbleDrive8 power/mode supervisor.
package bubbledrive8_pkg;

  // Supervisor state codes, visible on the STATE debug port.
  localparam logic [2:0] CODE_RESET         = 3'd0;
  localparam logic [2:0] CODE_MODE_SELECT   = 3'd1;
  localparam logic [2:0] CODE_EMULATOR      = 3'd2;
  localparam logic [2:0] CODE_MPSSE_STANDBY = 3'd5;
  localparam logic [2:0] CODE_ERROR_MRST    = 3'd6;
  localparam logic [2:0] CODE_ERROR_AMBIG   = 3'd7;

  typedef enum logic [2:0] {
    ST_RESET         = CODE_RESET,
    ST_MODE_SELECT   = CODE_MODE_SELECT,
    ST_EMULATOR      = CODE_EMULATOR,
    ST_MPSSE_STANDBY = CODE_MPSSE_STANDBY,
    ST_ERROR_MRST    = CODE_ERROR_MRST,
    ST_ERROR_AMBIG   = CODE_ERROR_AMBIG
  } state_e;

  // How an active-low LED is driven.
  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_ON   = 2'd1,
    LED_SLOW = 2'd2,
    LED_FAST = 2'd3
  } led_mode_e;

  // Registered, active-low output bundle.
  typedef struct packed {
    logic emu_n;
    logic temp_n;
    logic usb_n;
    logic acc_n;
    logic dly_n;
    logic stby_n;
    logic pwrok_n;
  } out_t;

  localparam out_t OUT_IDLE = '{default: 1'b1};

  // Active-low LED level for a mode; a blink phase of 0 means lit.
  function automatic logic led_level(led_mode_e mode, logic slow, logic fast);
    logic lvl;
    lvl = 1'b1;
    case (mode)
      LED_OFF:  lvl = 1'b1;
      LED_ON:   lvl = 1'b0;
      LED_SLOW: lvl = slow;
      default:  lvl = fast;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/bubbledrive8_debounce.sv
// Two-flop synchroniser followed by a counting debouncer. While SETTLE is
// high the output tracks the synchronised input every cycle.
module bubbledrive8_debounce #(
  parameter int CYCLES = 4800
) (
  input  logic MCLK,
  input  logic nRST,
  input  logic D,
  input  logic SETTLE,
  output logic Q
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             q_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous pin into the MCLK domain.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= D;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for CYCLES consecutive cycles.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (SETTLE) begin
      q_q   <= sync2_q;
      cnt_q <= '0;
    end else if (sync2_q != q_q) begin
      if (cnt_q == CNT_LAST) begin
        q_q   <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/bubbledrive8_supervisor.sv
// BubbleDrive8 power/mode supervisor: debounced power inputs, startup/mode
// FSM, LED blinker and registered active-low core enables.
module bubbledrive8_supervisor
  import bubbledrive8_pkg::*;
#(
  parameter int CLK_HZ          = 48000000,
  parameter int BLINK_HZ        = 1,
  parameter int DEBOUNCE_CYCLES = 4800
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       PWRSTAT,
  input  logic       MRST,
  input  logic       nDELAYING_IN,
  output logic       nEMU_EN,
  output logic       nTEMP_EN,
  output logic       nUSB_EN,
  output logic       nLED_ACC_EN,
  output logic       nLED_DELAYING,
  output logic       nLED_STANDBY,
  output logic       nLED_PWROK,
  output logic [2:0] STATE
);

  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int QUARTER = HALF / 4;
  localparam int CNT_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int FAST_W  = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int SET_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  HALF_LAST    = CNT_W'(HALF - 1);
  localparam logic [FAST_W-1:0] QUARTER_LAST = FAST_W'(QUARTER - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST  = SET_W'(DEBOUNCE_CYCLES - 1);

  logic              pwr_db;
  logic              mrst_db;
  logic              valid_q;
  logic [SET_W-1:0]  settle_cnt_q;
  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  blink_cnt_q;
  logic [FAST_W-1:0] fast_cnt_q;
  logic              slow_q;
  logic              fast_q;
  out_t              out_q;
  out_t              out_d;

  bubbledrive8_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pwr_db (
    .MCLK   (MCLK),
    .nRST   (nRST),
    .D      (PWRSTAT),
    .SETTLE (~valid_q),
    .Q      (pwr_db)
  );

  bubbledrive8_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mrst_db (
    .MCLK   (MCLK),
    .nRST   (nRST),
    .D      (MRST),
    .SETTLE (~valid_q),
    .Q      (mrst_db)
  );

  // Settle window after reset: debouncers track inputs until valid rises.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      settle_cnt_q <= '0;
      valid_q      <= 1'b0;
    end else if (!valid_q) begin
      if (settle_cnt_q == SETTLE_LAST) begin
        valid_q <= 1'b1;
      end else begin
        settle_cnt_q <= settle_cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic on the debounced pair {pwr_db, mrst_db}.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:       if (valid_q) state_d = ST_MODE_SELECT;
      ST_MODE_SELECT: begin
        case ({pwr_db, mrst_db})
          2'b00:   state_d = ST_EMULATOR;
          2'b01:   state_d = ST_ERROR_MRST;
          2'b10:   state_d = ST_ERROR_AMBIG;
          default: state_d = ST_MPSSE_STANDBY;
        endcase
      end
      ST_EMULATOR:      if (mrst_db) state_d = ST_ERROR_MRST;
      ST_MPSSE_STANDBY: begin
        if ({pwr_db, mrst_db} == 2'b00)      state_d = ST_RESET;
        else if ({pwr_db, mrst_db} == 2'b01) state_d = ST_ERROR_MRST;
      end
      ST_ERROR_MRST:  if (!mrst_db) state_d = ST_RESET;
      ST_ERROR_AMBIG: if ({pwr_db, mrst_db} != 2'b10) state_d = ST_RESET;
      default:        state_d = ST_RESET;
    endcase
  end

  // State register plus blinker, which restarts lit on every state change.
  // The fast phase has its own small divider so it toggles exactly every
  // HALF/4 cycles even when HALF is not a multiple of four.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_RESET;
      blink_cnt_q <= '0;
      fast_cnt_q  <= '0;
      slow_q      <= 1'b0;
      fast_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        blink_cnt_q <= '0;
        fast_cnt_q  <= '0;
        slow_q      <= 1'b0;
        fast_q      <= 1'b0;
      end else begin
        if (blink_cnt_q == HALF_LAST) begin
          blink_cnt_q <= '0;
          slow_q      <= ~slow_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
        if (fast_cnt_q == QUARTER_LAST) begin
          fast_cnt_q <= '0;
          fast_q     <= ~fast_q;
        end else begin
          fast_cnt_q <= fast_cnt_q + 1'b1;
        end
      end
    end
  end

  // Per-state output decode; anything not driven stays inactive.
  always_comb begin
    out_d = OUT_IDLE;
    case (state_q)
      ST_EMULATOR: begin
        out_d.emu_n   = 1'b0;
        out_d.temp_n  = 1'b0;
        out_d.usb_n   = 1'b0;
        out_d.acc_n   = 1'b0;
        out_d.pwrok_n = led_level(LED_ON, slow_q, fast_q);
        out_d.dly_n   = nDELAYING_IN;
      end
      ST_MPSSE_STANDBY: begin
        out_d.usb_n  = 1'b0;
        out_d.stby_n = led_level(LED_SLOW, slow_q, fast_q);
      end
      ST_ERROR_MRST:  out_d.pwrok_n = led_level(LED_SLOW, slow_q, fast_q);
      ST_ERROR_AMBIG: out_d.pwrok_n = led_level(LED_FAST, slow_q, fast_q);
      default: ;
    endcase
  end

  // Output register: outputs follow the state register by one cycle.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      out_q <= OUT_IDLE;
    end else begin
      out_q <= out_d;
    end
  end

  assign nEMU_EN       = out_q.emu_n;
  assign nTEMP_EN      = out_q.temp_n;
  assign nUSB_EN       = out_q.usb_n;
  assign nLED_ACC_EN   = out_q.acc_n;
  assign nLED_DELAYING = out_q.dly_n;
  assign nLED_STANDBY  = out_q.stby_n;
  assign nLED_PWROK    = out_q.pwrok_n;
  assign STATE         = state_q;

endmodule

// File: tb/tb_bubbledrive8_supervisor.sv
// Directed bench for bubbledrive8_supervisor with HALF=20, fast period 5,
// DEBOUNCE_CYCLES=8. Inputs change and outputs are sampled on the falling edge.
module tb_bubbledrive8_supervisor;

  logic       MCLK = 1'b0;
  logic       nRST;
  logic       PWRSTAT;
  logic       MRST;
  logic       nDELAYING_IN;
  logic       nEMU_EN;
  logic       nTEMP_EN;
  logic       nUSB_EN;
  logic       nLED_ACC_EN;
  logic       nLED_DELAYING;
  logic       nLED_STANDBY;
  logic       nLED_PWROK;
  logic [2:0] STATE;
  logic [6:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector order: emu, temp, usb, acc, delaying, standby, pwrok.
  localparam logic [6:0] O_IDLE  = 7'b1111111;
  localparam logic [6:0] O_EMU   = 7'b0000110;
  localparam logic [6:0] O_EMUD  = 7'b0000010;
  localparam logic [6:0] O_MRST  = 7'b1111110;
  localparam logic [6:0] O_STBY  = 7'b1101101;
  localparam logic [6:0] O_STBYD = 7'b1101111;

  assign outs = {nEMU_EN, nTEMP_EN, nUSB_EN, nLED_ACC_EN,
                 nLED_DELAYING, nLED_STANDBY, nLED_PWROK};

  bubbledrive8_supervisor #(
    .CLK_HZ          (1000),
    .BLINK_HZ        (25),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .MCLK          (MCLK),
    .nRST          (nRST),
    .PWRSTAT       (PWRSTAT),
    .MRST          (MRST),
    .nDELAYING_IN  (nDELAYING_IN),
    .nEMU_EN       (nEMU_EN),
    .nTEMP_EN      (nTEMP_EN),
    .nUSB_EN       (nUSB_EN),
    .nLED_ACC_EN   (nLED_ACC_EN),
    .nLED_DELAYING (nLED_DELAYING),
    .nLED_STANDBY  (nLED_STANDBY),
    .nLED_PWROK    (nLED_PWROK),
    .STATE         (STATE)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  initial begin
    nRST         = 1'b0;
    PWRSTAT      = 1'b0;
    MRST         = 1'b0;
    nDELAYING_IN = 1'b1;
    step(2);
    check("reset_state", 8'(STATE), 8'd0);
    check("reset_outs", 8'(outs), 8'(O_IDLE));

    // Power-up on motherboard supply: 0 -> 1 -> 2.
    nRST = 1'b1;
    step(8);
    check("settle_state", 8'(STATE), 8'd0);
    check("settle_outs", 8'(outs), 8'(O_IDLE));
    step(1);
    check("pu_mode_select", 8'(STATE), 8'd1);
    step(1);
    check("pu_emulator", 8'(STATE), 8'd2);
    check("pu_outs_lag", 8'(outs), 8'(O_IDLE));
    step(1);
    check("pu_emu_outs", 8'(outs), 8'(O_EMU));
    nDELAYING_IN = 1'b0;
    step(1);
    check("emu_delaying_low", 8'(outs), 8'(O_EMUD));
    nDELAYING_IN = 1'b1;
    step(1);
    check("emu_delaying_high", 8'(outs), 8'(O_EMU));

    // Short MRST glitch is rejected.
    MRST = 1'b1;
    step(5);
    MRST = 1'b0;
    step(20);
    check("glitch_state", 8'(STATE), 8'd2);
    check("glitch_outs", 8'(outs), 8'(O_EMU));

    // Power loss mid-emulation: 2 + 8 + 1 cycles to ERROR_MRST.
    MRST = 1'b1;
    step(10);
    check("ploss_pre", 8'(STATE), 8'd2);
    step(1);
    check("ploss_state", 8'(STATE), 8'd6);
    check("ploss_outs_lag", 8'(outs), 8'(O_EMU));
    step(1);
    check("ploss_outs", 8'(outs), 8'(O_MRST));
    step(19);
    check("mrst_blink_lit_end", 8'(nLED_PWROK), 8'd0);
    step(1);
    check("mrst_blink_dark", 8'(nLED_PWROK), 8'd1);
    step(19);
    check("mrst_blink_dark_end", 8'(nLED_PWROK), 8'd1);
    step(1);
    check("mrst_blink_relit", 8'(nLED_PWROK), 8'd0);

    // PWRSTAT=1, MRST=0 together: ERROR_MRST -> RESET -> MODE_SELECT -> ERROR_AMBIG.
    PWRSTAT = 1'b1;
    MRST    = 1'b0;
    step(10);
    check("amb_pre", 8'(STATE), 8'd6);
    step(1);
    check("amb_reset", 8'(STATE), 8'd0);
    step(1);
    check("amb_mode_select", 8'(STATE), 8'd1);
    step(1);
    check("amb_state", 8'(STATE), 8'd7);
    step(1);
    check("amb_outs", 8'(outs), 8'(O_MRST));
    step(4);
    check("fast_lit_end", 8'(nLED_PWROK), 8'd0);
    step(1);
    check("fast_dark", 8'(nLED_PWROK), 8'd1);
    step(4);
    check("fast_dark_end", 8'(nLED_PWROK), 8'd1);
    step(1);
    check("fast_relit", 8'(nLED_PWROK), 8'd0);

    // Ambiguity resolved: back through RESET to EMULATOR.
    PWRSTAT = 1'b0;
    step(10);
    check("amb_exit_pre", 8'(STATE), 8'd7);
    step(1);
    check("amb_exit_reset", 8'(STATE), 8'd0);
    step(1);
    check("amb_exit_mode", 8'(STATE), 8'd1);
    step(1);
    check("amb_exit_emu", 8'(STATE), 8'd2);
    step(1);
    check("amb_exit_outs", 8'(outs), 8'(O_EMU));

    // PWRSTAT changes are ignored in EMULATOR.
    PWRSTAT = 1'b1;
    step(20);
    check("emu_ignore_pwr", 8'(STATE), 8'd2);
    check("emu_ignore_outs", 8'(outs), 8'(O_EMU));

    // Asynchronous reset mid-emulation; inputs now select USB mode.
    @(negedge MCLK);
    nRST = 1'b0;
    MRST = 1'b1;
    #1;
    check("async_rst_state", 8'(STATE), 8'd0);
    check("async_rst_outs", 8'(outs), 8'(O_IDLE));
    step(2);
    nRST = 1'b1;
    step(8);
    check("resettle_state", 8'(STATE), 8'd0);
    check("resettle_outs", 8'(outs), 8'(O_IDLE));
    step(1);
    check("usb_mode_select", 8'(STATE), 8'd1);
    step(1);
    check("usb_state", 8'(STATE), 8'd5);
    step(1);
    check("usb_outs", 8'(outs), 8'(O_STBY));
    step(19);
    check("stby_lit_end", 8'(outs), 8'(O_STBY));
    step(1);
    check("stby_dark", 8'(outs), 8'(O_STBYD));
    step(19);
    check("stby_dark_end", 8'(nLED_STANDBY), 8'd1);
    step(1);
    check("stby_relit", 8'(nLED_STANDBY), 8'd0);

    // USB supply drops while PCB power is bad: MPSSE_STANDBY -> ERROR_MRST.
    PWRSTAT = 1'b0;
    step(10);
    check("stby_drop_pre", 8'(STATE), 8'd5);
    step(1);
    check("stby_drop_state", 8'(STATE), 8'd6);
    step(1);
    check("stby_drop_outs", 8'(outs), 8'(O_MRST));

    // PCB power recovers: RESET -> MODE_SELECT -> EMULATOR.
    MRST = 1'b0;
    step(10);
    check("recover_pre", 8'(STATE), 8'd6);
    step(1);
    check("recover_reset", 8'(STATE), 8'd0);
    step(1);
    check("recover_mode", 8'(STATE), 8'd1);
    step(1);
    check("recover_emu", 8'(STATE), 8'd2);
    step(1);
    check("recover_outs", 8'(outs), 8'(O_EMU));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
